// File: rtl/attrs_pkg.sv
// Shared sizing parameters and word/address types for the instruction ROM.
package attrs;
  localparam int N_CORES   = 4;
  localparam int ROM_DEPTH = 256;
  localparam int ROM_AW    = $clog2(ROM_DEPTH);

  typedef logic [31:0]       ir_word_t;
  typedef logic [ROM_AW-1:0] rom_addr_t;
endpackage

// File: rtl/prog_rom_if.sv
// Bus bundle for prog_rom: loader handshake, core reset request and the
// per-core read ports. The master side (loader + cores) drives requests,
// the slave side (the ROM) answers them.
interface prog_rom_if;
  import attrs::*;

  // loader handshake
  logic                      prog;
  logic                      p_avail;
  ir_word_t                  p_d_in;
  logic                      p_ready;
  logic                      p_lo_ack;
  logic                      core_rst;

  // per-core read ports
  logic      [N_CORES-1:0]   active;
  rom_addr_t [N_CORES-1:0]   addr;
  ir_word_t  [N_CORES-1:0]   d_out;
  logic      [N_CORES-1:0]   ready;

  modport master (
    output prog, p_avail, p_d_in, active, addr,
    input  p_ready, p_lo_ack, core_rst, d_out, ready
  );

  modport slave (
    input  prog, p_avail, p_d_in, active, addr,
    output p_ready, p_lo_ack, core_rst, d_out, ready
  );
endinterface

// File: rtl/prog_rom.sv
// prog_rom: shared instruction ROM for the multi-core array.
// Loaded word-by-word over a four-phase handshake while the cores are held
// in reset; afterwards one read port is shared by all cores through a
// round-robin arbiter, and each core keeps a private registered data word.
// Optional feature macro: PROG_ROM_OVF_GUARD_EN -- when defined, the write
// pointer saturates after the last word and surplus words are discarded
// (handshake still completes); otherwise the pointer wraps to address 0.
module prog_rom
  import attrs::*;
(
  input  logic         clk,
  input  logic         rst_n,
  prog_rom_if.slave    bus
);

  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam rom_addr_t LAST_ADDR = rom_addr_t'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ACK  = 2'd3
  } ld_state_t;

  // storage (contents are never reset)
  ir_word_t mem [ROM_DEPTH];

  // loader state
  ld_state_t state_q, state_d;
  rom_addr_t wptr_q, wptr_d;
  logic      prog_ff_q;
  logic      prog_rising;
  logic      mem_we;
  logic      core_rst;
`ifdef PROG_ROM_OVF_GUARD_EN
  logic      full_q, full_d;
`endif

  // read slots and arbiter
  logic      [N_CORES-1:0] valid_q;
  rom_addr_t [N_CORES-1:0] lat_addr_q;
  ir_word_t  [N_CORES-1:0] d_out_q;
  logic      [CW-1:0]      gptr_q;
  logic      [N_CORES-1:0] ready_w;
  logic      [N_CORES-1:0] pending;
  logic                    grant_vld;
  logic      [CW-1:0]      grant_idx;
  rom_addr_t               rd_addr;

  assign prog_rising  = bus.prog & ~prog_ff_q;
  assign core_rst     = ~rst_n | bus.prog | prog_ff_q;
  assign bus.core_rst = core_rst;
  assign bus.p_ready  = (state_q == S_HOLD);
  assign bus.p_lo_ack = (state_q == S_ACK);

  // Loader state, write pointer and prog edge detector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      prog_ff_q <= 1'b0;
`ifdef PROG_ROM_OVF_GUARD_EN
      full_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      prog_ff_q <= bus.prog;
`ifdef PROG_ROM_OVF_GUARD_EN
      full_q    <= full_d;
`endif
    end
  end

  // Loader next-state: dropping prog always aborts, a prog edge restarts at 0
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    mem_we  = 1'b0;
`ifdef PROG_ROM_OVF_GUARD_EN
    full_d  = full_q;
`endif
    if (!bus.prog) begin
      state_d = S_IDLE;
    end else if (prog_rising) begin
      state_d = S_WAIT;
      wptr_d  = '0;
`ifdef PROG_ROM_OVF_GUARD_EN
      full_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        S_WAIT, S_ACK: begin
          if (bus.p_avail) begin
`ifdef PROG_ROM_OVF_GUARD_EN
            mem_we = ~full_q;
`else
            mem_we = 1'b1;
`endif
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!bus.p_avail) begin
            state_d = S_ACK;
`ifdef PROG_ROM_OVF_GUARD_EN
            if (wptr_q == LAST_ADDR) full_d = 1'b1;
            else                     wptr_d = wptr_q + 1'b1;
`else
            wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Write port (loader only; qualified by rst_n so a reset aborts cleanly)
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[wptr_q] <= bus.p_d_in;
  end

  // Per-core ready: slot holds the word for exactly the address now presented
  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_slot
    assign ready_w[gi] = bus.active[gi] & valid_q[gi] &
                         (lat_addr_q[gi] == bus.addr[gi]);
  end
  assign pending   = bus.active & ~ready_w;
  assign bus.ready = ready_w;
  assign bus.d_out = d_out_q;
  assign rd_addr   = bus.addr[grant_idx];

  // Round-robin pick: search starts one past the last granted core
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = gptr_q;
    for (int k = 1; k <= N_CORES; k++) begin
      if (!grant_vld && !core_rst && pending[(int'(gptr_q) + k) % N_CORES]) begin
        grant_vld = 1'b1;
        grant_idx = CW'((int'(gptr_q) + k) % N_CORES);
      end
    end
  end

  // Read slots: registered read into the granted core's private data word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      lat_addr_q <= '0;
      d_out_q    <= '0;
      gptr_q     <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (core_rst || !bus.active[i]) valid_q[i] <= 1'b0;
      end
      if (grant_vld) begin
        valid_q[grant_idx]    <= 1'b1;
        lat_addr_q[grant_idx] <= rd_addr;
        d_out_q[grant_idx]    <= mem[rd_addr];
        gptr_q                <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_prog_rom.sv
// Self-checking bench for prog_rom: loads words through the handshake,
// then reads them back through the arbitrated core ports. Expected words
// come from a bench-side memory model and are queued at request time.
module tb_prog_rom;
  import attrs::*;

  typedef struct {
    int          core;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  prog_rom_if bus();

  prog_rom dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          last_grant = 0;
  logic [31:0] model [ROM_DEPTH];
  logic [31:0] wbuf  [ROM_DEPTH + 1];
  exp_t        sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // One full load of n words from wbuf, updating the model as the ROM should
  task automatic load(input int n, input bit verbose);
    int  ptr;
    bit  tmo;
    ptr = 0;
    @(negedge clk);
    bus.prog = 1'b1;
    for (int w = 0; w < n; w++) begin
      @(negedge clk);
      bus.p_avail = 1'b1;
      bus.p_d_in  = wbuf[w];
      tmo = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.p_ready) begin tmo = 1'b0; break; end
      end
      if (tmo) check("p_ready_timeout", 32'd0, 32'd1);
      else begin
        check("ack_low_while_ready", 32'(bus.p_lo_ack), 32'd0);
        check("core_rst_in_load", 32'(bus.core_rst), 32'd1);
      end
      bus.p_avail = 1'b0;
      tmo = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.p_lo_ack) begin tmo = 1'b0; break; end
      end
      if (tmo) check("p_lo_ack_timeout", 32'd0, 32'd1);
      else begin
        check("ready_low_while_ack", 32'(bus.p_ready), 32'd0);
        check("core_rst_in_ack", 32'(bus.core_rst), 32'd1);
      end
`ifdef PROG_ROM_OVF_GUARD_EN
      if (ptr < ROM_DEPTH) model[ptr] = wbuf[w];
`else
      model[ptr % ROM_DEPTH] = wbuf[w];
`endif
      ptr++;
      if (verbose) $display("load  word %0d = %h", w, wbuf[w]);
    end
    @(negedge clk);
    bus.prog = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Single-core read: check latency, data, arbitration target and data hold
  task automatic read1(input int c, input int a, input int exp_lat);
    exp_t e;
    bit   tmo;
    int   lat;
    @(negedge clk);
    bus.active[c] = 1'b1;
    bus.addr[c]   = rom_addr_t'(a);
    sb.push_back('{c, model[a]});
    tmo = 1'b1;
    lat = 0;
    for (int k = 0; k < N_CORES + 4; k++) begin
      @(negedge clk);
      lat++;
      if (bus.ready[c]) begin tmo = 1'b0; break; end
    end
    e = sb.pop_front();
    if (tmo) check("read_timeout", 32'd0, 32'd1);
    else begin
      if (exp_lat > 0) check("read_latency", 32'(lat), 32'(exp_lat));
      check("read_data", bus.d_out[c], e.data);
      @(negedge clk);
      check("read_hold", bus.d_out[c], e.data);
      last_grant = c;
      $display("read  core %0d addr %0d data %h latency %0d", c, a, bus.d_out[c], lat);
    end
    bus.active[c] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bit   seen [N_CORES];
    int   n_seen;
    int   cyc;
    bit   tmo;

    rst_n       = 1'b0;
    bus.prog    = 1'b0;
    bus.p_avail = 1'b0;
    bus.p_d_in  = '0;
    bus.active  = '0;
    bus.addr    = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_p_ready", 32'(bus.p_ready), 32'd0);
    check("rst_p_lo_ack", 32'(bus.p_lo_ack), 32'd0);
    check("rst_core_rst", 32'(bus.core_rst), 32'd1);
    check("rst_ready", 32'(bus.ready), 32'd0);
    for (int c = 0; c < N_CORES; c++) check("rst_d_out", bus.d_out[c], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("core_rst_released", 32'(bus.core_rst), 32'd0);

    // three-word load, then every core reads them back one at a time
    for (int w = 0; w < 3; w++) wbuf[w] = $urandom;
    load(3, 1'b1);
    check("core_rst_after_load", 32'(bus.core_rst), 32'd0);
    for (int c = 0; c < N_CORES; c++)
      for (int a = 0; a < 3; a++) read1(c, a, 1);

    // all cores request the same address: round-robin order after last grant
    @(negedge clk);
    for (int k = 1; k <= N_CORES; k++) begin
      int c;
      c = (last_grant + k) % N_CORES;
      sb.push_back('{c, model[1]});
    end
    for (int c = 0; c < N_CORES; c++) begin
      bus.active[c] = 1'b1;
      bus.addr[c]   = rom_addr_t'(1);
      seen[c]       = 1'b0;
    end
    n_seen = 0;
    cyc    = 0;
    for (int k = 0; k < N_CORES + 3 && n_seen < N_CORES; k++) begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < N_CORES; c++) begin
        if (bus.ready[c] && !seen[c]) begin
          seen[c] = 1'b1;
          n_seen++;
          e = sb.pop_front();
          check("rr_order", 32'(c), 32'(e.core));
          check("rr_data", bus.d_out[c], e.data);
          last_grant = c;
          $display("read  core %0d addr 1 data %h cycle %0d", c, bus.d_out[c], cyc);
        end
      end
    end
    check("rr_all_ready", 32'(n_seen), 32'(N_CORES));
    check("rr_within_n", 32'(cyc <= N_CORES), 32'd1);
    sb.delete();
    bus.active = '0;

    // read requested while prog is high stays pending until core_rst falls
    @(negedge clk);
    bus.prog      = 1'b1;
    bus.active[2] = 1'b1;
    bus.addr[2]   = rom_addr_t'(2);
    repeat (3) @(negedge clk);
    check("pend_in_prog", 32'(bus.ready[2]), 32'd0);
    bus.prog = 1'b0;
    tmo = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ready[2]) begin tmo = 1'b0; break; end
    end
    check("pend_granted", 32'(tmo), 32'd0);
    check("pend_data", bus.d_out[2], model[2]);
    bus.active[2] = 1'b0;
    last_grant = 2;

    // full load, then core 0 sweeps every address with active held high
    for (int w = 0; w < ROM_DEPTH; w++) wbuf[w] = $urandom;
    load(ROM_DEPTH, 1'b0);
    @(negedge clk);
    bus.active[0] = 1'b1;
    bus.addr[0]   = '0;
    sb.push_back('{0, model[0]});
    for (int a = 0; a < ROM_DEPTH; a++) begin
      tmo = 1'b1;
      for (int k = 0; k < N_CORES + 4; k++) begin
        @(negedge clk);
        if (bus.ready[0]) begin tmo = 1'b0; break; end
      end
      e = sb.pop_front();
      if (tmo) begin
        check("sweep_timeout", 32'd0, 32'd1);
        break;
      end
      check("sweep_data", bus.d_out[0], e.data);
      if (a < ROM_DEPTH - 1) begin
        bus.addr[0] = rom_addr_t'(a + 1);
        sb.push_back('{0, model[a + 1]});
        #1;
        check("sweep_ready_drop", 32'(bus.ready[0]), 32'd0);
      end
    end
    $display("read  core 0 sweep of %0d addresses done", ROM_DEPTH);
    sb.delete();
    bus.active = '0;
    last_grant = 0;

    // overflow: one word more than the ROM holds
    for (int w = 0; w <= ROM_DEPTH; w++) wbuf[w] = $urandom;
    load(ROM_DEPTH + 1, 1'b0);
    read1(0, 0, 1);
    read1(1, ROM_DEPTH - 1, 1);
    read1(3, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_rom.md
# prog_rom

Shared instruction ROM for the multi-core array. An external loader writes it word-by-word over a four-phase handshake while holding all cores in reset. During normal operation it serves per-core read requests through a single read port with round-robin arbitration. Each core receives a private registered data word plus an address-qualified ready.

## Interface
Parameters come from package `attrs`:
- N_CORES, 4, number of core read ports.
- ROM_DEPTH, 256, number of words.
- ir_word_t, 32-bit, instruction word type.
- rom_addr_t, $clog2(ROM_DEPTH) bits, address type.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- prog  in  1  programming mode; a rising edge starts a new load at address 0.
- p_avail  in  1  loader has a valid word on p_d_in.
- p_d_in  in  ir_word_t  loader data.
- p_ready  out  1  word captured; held until p_avail falls.
- p_lo_ack  out  1  p_avail low seen and word retired; held until the next p_avail.
- core_rst  out  1  core reset request.
- active  in  [N_CORES]  per-core read request.
- addr  in  rom_addr_t[N_CORES]  per-core read address.
- d_out  out  ir_word_t[N_CORES]  per-core registered read data.
- ready  out  [N_CORES]  d_out[i] holds mem[addr[i]].

## Operation
- Storage: ROM_DEPTH x ir_word_t array. Contents are not reset.
- Internal signals: prog_ff (prog delayed one cycle) and prog_rising = prog & ~prog_ff.
- core_rst = ~rst_n | prog | prog_ff (combinational).
- Loader FSM states:
  - IDLE: prog low.
  - WAIT: expecting first word.
  - HOLD: p_ready=1.
  - ACK: p_lo_ack=1.
- Loader FSM transitions:
  - prog_rising: wptr<=0, go to WAIT.
  - WAIT or ACK with p_avail=1: mem[wptr]<=p_d_in, go to HOLD.
  - HOLD with p_avail=0: wptr<=wptr+1, go to ACK.
  - prog=0 in any state: go to IDLE.
- p_ready and p_lo_ack are decoded from state and are never high together.
- wptr wraps from ROM_DEPTH-1 to 0, so exactly ROM_DEPTH words fill the ROM.
- Per-core read slot i: valid[i], lat_addr[i], d_out[i].
- ready[i] = active[i] & valid[i] & (lat_addr[i]==addr[i]) (combinational). A core changing addr while active drops ready in the same cycle.
- Pending[i] = active[i] & ~ready[i].
  - One pending core is granted per cycle, round-robin starting after the last grant.
  - The granted slot latches d_out<=mem[addr], lat_addr<=addr, valid<=1.
- valid[i] clears when active[i]=0.
- While core_rst is high: no grants and all valid clear.
- d_out[i] holds its value until that slot's next grant.

## Timing
- Reset values: p_ready=0, p_lo_ack=0, loader state IDLE, wptr=0, prog_ff=0, ready=0, d_out=0, grant pointer=0, core_rst=1.
- Loader:
  - p_ready rises 1 cycle after p_avail=1 is sampled in WAIT or ACK.
  - p_lo_ack rises 1 cycle after p_avail=0 is sampled in HOLD.
  - The first p_avail can be sampled the cycle after prog_rising.
- Read latency:
  - Minimum: ready rises one edge after a request.
  - Maximum: N_CORES edges when all cores are pending.
  - d_out is stable from that edge while addr is unchanged.
- Simultaneous events:
  - prog rising with p_avail=1: the word is written on the following edge.
  - Reads requested while prog is high stay pending and are granted after core_rst falls.
- rst_n low mid-load: load aborts; already-written words remain in memory.

## Configuration
- PROG_ROM_OVF_GUARD_EN defined:
  - After mem[ROM_DEPTH-1] is written, wptr saturates.
  - Further words complete the handshake normally but are discarded until the next prog_rising.
- Undefined: wptr wraps to 0 and overwrites from the start.

## Test plan
- Load 3 random words (A,B,C) at addresses 0..2 via the handshake; check core_rst=1 throughout and that p_ready and p_lo_ack alternate and never overlap.
- Core 0 reads addresses 0,1,2 one at a time. After ready then one clock: d_out[0] = A, B, C.
- Each core 1..N_CORES-1 reads addresses 0..2 individually; d_out matches A,B,C.
- All cores request the same address simultaneously; all ready within N_CORES cycles with identical correct data; grant order round-robin.
- Load ROM_DEPTH random words, then have core 0 read all addresses with active held high and addr stepped each time ready is seen; every word matches and ready drops the same cycle addr changes.
- Overflow: load ROM_DEPTH+1 words.
  - PROG_ROM_OVF_GUARD_EN defined: address 0 keeps the first word.
  - Undefined: address 0 holds the last word.
